// File: rtl/cp0_exc_ctrl_if.sv
// Bundle of the CP0 exception controller's pipeline-side and CP0-side signals.
// The slave modport is the controller's view; master is the surrounding pipeline/CP0.
interface cp0_exc_ctrl_if;
    logic [5:0]  interrupt_i;
    logic        timer_interrupt_i;
    logic [31:0] mem_excepttype_i;
    logic [31:0] mem_pc_i;
    logic        mem_is_delayslot_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [31:0] cp0_wdata_i;

    logic [5:0]  cp0_interrupt_o;
    logic [31:0] excepttype_o;
    logic        exc_we_o;
    logic [31:0] exc_epc_o;
    logic        exc_bd_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;

    modport slave (
        input  interrupt_i, timer_interrupt_i, mem_excepttype_i, mem_pc_i,
               mem_is_delayslot_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
               cp0_we_i, cp0_waddr_i, cp0_wdata_i,
        output cp0_interrupt_o, excepttype_o, exc_we_o, exc_epc_o, exc_bd_o,
               flush_o, new_pc_o, busy_o
    );

    modport master (
        output interrupt_i, timer_interrupt_i, mem_excepttype_i, mem_pc_i,
               mem_is_delayslot_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
               cp0_we_i, cp0_waddr_i, cp0_wdata_i,
        input  cp0_interrupt_o, excepttype_o, exc_we_o, exc_epc_o, exc_bd_o,
               flush_o, new_pc_o, busy_o
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: synchronizes interrupts, resolves MEM-stage exceptions
// and sequences a one-cycle flush followed by a fixed drain period.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input logic          clk,
    input logic          rst,
    cp0_exc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FLUSH, WAIT} state_t;

    localparam logic [2:0] CNT_LAST = 3'(DRAIN_CYCLES - 1);

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [31:0] type_reg, type_next;
    logic [31:0] epc_reg, epc_next;
    logic        bd_reg, bd_next;
    logic [31:0] newpc_reg, newpc_next;

    logic [5:0]  sync0_reg, sync1_reg;

    // Two-flop synchronizer per external interrupt line.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync0_reg[gi] <= 1'b0;
                    sync1_reg[gi] <= 1'b0;
                end else begin
                    sync0_reg[gi] <= bus.interrupt_i[gi];
                    sync1_reg[gi] <= sync0_reg[gi];
                end
            end
        end
    endgenerate

    assign bus.cp0_interrupt_o = {sync1_reg[5] | bus.timer_interrupt_i, sync1_reg[4:0]};

    // Forward an in-flight mtc0 so detection sees the value CP0 is about to hold.
    logic [31:0] eff_status, eff_cause, eff_epc;
    logic        fwd_status, fwd_cause, fwd_epc;

    assign fwd_status = bus.cp0_we_i && (bus.cp0_waddr_i == ADDR_STATUS);
    assign fwd_cause  = bus.cp0_we_i && (bus.cp0_waddr_i == ADDR_CAUSE);
    assign fwd_epc    = bus.cp0_we_i && (bus.cp0_waddr_i == ADDR_EPC);

    always_comb begin
        eff_status = fwd_status ? bus.cp0_wdata_i : bus.cp0_status_i;
        eff_epc    = fwd_epc    ? bus.cp0_wdata_i : bus.cp0_epc_i;
        eff_cause  = bus.cp0_cause_i;
        if (fwd_cause) begin
            eff_cause[9:8] = bus.cp0_wdata_i[9:8];
            eff_cause[22]  = bus.cp0_wdata_i[22];
            eff_cause[23]  = bus.cp0_wdata_i[23];
        end
    end

    logic        int_pending;
    logic [31:0] exc_code;
    logic        exc_detect;

    assign int_pending = ((eff_cause[15:8] & eff_status[15:8]) != 8'h00)
                         && !eff_status[1] && eff_status[0];

    always_comb begin
        exc_code = 32'h0;
        if (int_pending)                   exc_code = 32'h1;
        else if (bus.mem_excepttype_i[8])  exc_code = 32'h8;
        else if (bus.mem_excepttype_i[9])  exc_code = 32'ha;
        else if (bus.mem_excepttype_i[10]) exc_code = 32'hd;
        else if (bus.mem_excepttype_i[11]) exc_code = 32'hc;
        else if (bus.mem_excepttype_i[12]) exc_code = 32'he;
    end

    assign exc_detect = (state_reg == IDLE) && (bus.mem_pc_i != 32'h0) && (exc_code != 32'h0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            type_reg  <= 32'h0;
            epc_reg   <= 32'h0;
            bd_reg    <= 1'b0;
            newpc_reg <= 32'h0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            type_reg  <= type_next;
            epc_reg   <= epc_next;
            bd_reg    <= bd_next;
            newpc_reg <= newpc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        type_next  = type_reg;
        epc_next   = epc_reg;
        bd_next    = bd_reg;
        newpc_next = newpc_reg;
        case (state_reg)
            IDLE: begin
                if (exc_detect) begin
                    state_next = FLUSH;
                    type_next  = exc_code;
                    bd_next    = bus.mem_is_delayslot_i;
                    epc_next   = bus.mem_is_delayslot_i ? (bus.mem_pc_i - 32'd4) : bus.mem_pc_i;
                    newpc_next = (exc_code == 32'he) ? eff_epc : EXC_VECTOR;
                end else begin
                    type_next  = 32'h0;
                    epc_next   = 32'h0;
                    bd_next    = 1'b0;
                    newpc_next = 32'h0;
                end
            end
            FLUSH: begin
                state_next = WAIT;
                cnt_next   = 3'd0;
            end
            WAIT: begin
                // Exit on the last drain cycle so the counter never wraps.
                if (cnt_reg == CNT_LAST) state_next = IDLE;
                else                     cnt_next   = cnt_reg + 3'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    logic in_flush;
    assign in_flush = (state_reg == FLUSH);

    assign bus.flush_o      = in_flush;
    assign bus.exc_we_o     = in_flush;
    assign bus.busy_o       = (state_reg != IDLE);
    assign bus.excepttype_o = in_flush ? type_reg  : 32'h0;
    assign bus.exc_epc_o    = in_flush ? epc_reg   : 32'h0;
    assign bus.exc_bd_o     = in_flush ? bd_reg    : 1'b0;
    assign bus.new_pc_o     = in_flush ? newpc_reg : 32'h0;

    logic unused_bits;
    assign unused_bits = ^{eff_status[31:16], eff_status[7:2], eff_cause[31:16],
                           eff_cause[7:0], bus.mem_excepttype_i[31:13],
                           bus.mem_excepttype_i[7:0]};
endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h00000020: redirect PC for every exception except eret.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 2: number of WAIT cycles after FLUSH. Legal range is 1..7.
REQ-003 SHALL have input clk (1 bit), the single clock.
REQ-004 SHALL have input rst (1 bit), an asynchronous, active-low reset.
REQ-005 SHALL have input interrupt_i (6 bits): raw asynchronous external interrupt lines.
REQ-006 SHALL have input timer_interrupt_i (1 bit): the CP0 timer interrupt, already synchronous.
REQ-007 SHALL have input mem_excepttype_i (32 bits): MEM-stage flags, assigned as follows.
- bit8 syscall
- bit9 invalid instruction
- bit10 trap
- bit11 overflow
- bit12 eret
REQ-008 SHALL have input mem_pc_i (32 bits): MEM-stage instruction address. A value of 0 means bubble.
REQ-009 SHALL have input mem_is_delayslot_i (1 bit): the MEM-stage instruction is in a delay slot.
REQ-010 SHALL have inputs cp0_status_i, cp0_cause_i and cp0_epc_i (32 bits each): current CP0 register values.
REQ-011 SHALL have inputs cp0_we_i (1), cp0_waddr_i (5) and cp0_wdata_i (32): the in-flight mtc0 write from MEM/WB, used for forwarding.
REQ-012 SHALL have output cp0_interrupt_o (6 bits): synchronized interrupts to CP0 Cause[15:10].
REQ-013 SHALL have output excepttype_o (32 bits): the resolved exception code.
REQ-014 SHALL have output exc_we_o (1 bit): a one-cycle pulse commanding CP0 to record the exception.
REQ-015 SHALL have output exc_epc_o (32 bits): the EPC value to record.
REQ-016 SHALL have output exc_bd_o (1 bit): the Cause.BD value to record.
REQ-017 SHALL have output flush_o (1 bit): pipeline flush, one cycle.
REQ-018 SHALL have output new_pc_o (32 bits): redirect target, valid while flush_o is high.
REQ-019 SHALL have output busy_o (1 bit): stalls the front end while the block is not IDLE.

Function
REQ-020 SHALL synchronize each interrupt_i bit through 2 flops.
REQ-021 SHALL drive cp0_interrupt_o = {sync[5] | timer_interrupt_i, sync[4:0]}; the timer is not synchronized.
REQ-022 SHALL form effective Status/Cause/EPC by forwarding the matching field of cp0_wdata_i when cp0_we_i=1 and cp0_waddr_i matches the register.
- Status = 12
- Cause = 13, bits [9:8], 22 and 23 only
- EPC = 14
REQ-023 SHALL detect an exception only in IDLE and only when mem_pc_i != 0.
REQ-024 SHALL detect an interrupt when (effCause[15:8] & effStatus[15:8]) != 0 && effStatus[1]==0 && effStatus[0]==1.
REQ-025 SHALL resolve exception codes in this fixed priority order.
- interrupt 32'h1
- syscall 32'h8
- invalid 32'ha
- trap 32'hd
- overflow 32'hc
- eret 32'he
- none 32'h0
REQ-026 SHALL use a three-state FSM: IDLE, FLUSH, WAIT.
- IDLE to FLUSH when an exception is detected.
- FLUSH to WAIT unconditionally.
- WAIT to IDLE when the drain counter reaches DRAIN_CYCLES-1.
REQ-027 SHALL register all detection results at the detecting edge, so outputs appear in the FLUSH cycle (latency 1 clock from detection).
REQ-028 SHALL, in FLUSH, drive flush_o=1 and exc_we_o=1 for exactly one cycle, and hold excepttype_o, exc_epc_o and exc_bd_o.
REQ-029 SHALL set exc_epc_o = mem_pc_i - 4 and exc_bd_o=1 when mem_is_delayslot_i=1; otherwise exc_epc_o = mem_pc_i and exc_bd_o=0.
REQ-030 SHALL set new_pc_o = effEPC for eret and EXC_VECTOR for all other exceptions.
REQ-031 SHALL hold busy_o=1 in FLUSH and WAIT, and 0 in IDLE.
REQ-032 SHALL ignore mem_excepttype_i and interrupts in FLUSH and WAIT, since those instructions are flushed; interrupts stay pending in CP0.
REQ-033 SHALL clear the drain counter on entry to WAIT, increment it each WAIT cycle, and never let it wrap.
REQ-034 SHALL zero excepttype_o, exc_epc_o and exc_bd_o in IDLE with no exception.
REQ-035 SHALL, on a simultaneous interrupt and synchronous exception, take the interrupt using the same exc_epc_o (instruction not committed).
REQ-036 SHALL re-evaluate a new exception arriving in the first IDLE cycle after WAIT normally; back-to-back handling is allowed.

Reset
REQ-037 SHALL, while rst=0 (asynchronous, no clock required), force the FSM to IDLE and the counter to 0.
REQ-038 SHALL, while rst=0, clear the synchronizer flops so that cp0_interrupt_o=0, apart from the timer input OR'd into bit 5.
REQ-039 SHALL, while rst=0, drive all other outputs to 0: flush_o, exc_we_o, busy_o, new_pc_o, excepttype_o, exc_epc_o, exc_bd_o.
REQ-040 SHALL abort a sequence on reset mid-FLUSH or mid-WAIT, with no residual pulse after deassertion.
REQ-041 SHALL leave the block in IDLE one clock after rst is deasserted.

Verification
REQ-042 SHALL cover syscall: mem_excepttype_i bit8 with pc=32'h100.
- Next cycle: flush_o=1, exc_we_o=1, excepttype_o=32'h8, exc_epc_o=32'h100, new_pc_o=32'h20.
- busy_o stays high for 1+DRAIN_CYCLES cycles.
REQ-043 SHALL cover a delay-slot overflow: bit11 with pc=32'h204 and delayslot=1, giving exc_epc_o=32'h200, exc_bd_o=1, excepttype_o=32'hc.
REQ-044 SHALL cover interrupt gating, with interrupt_i[2] high, Status=32'h0000_1001 and pc=32'h300.
- excepttype_o=32'h1 from cycle 3 after the interrupt is asserted.
- With Status[1]=1 (EXL): no flush.
REQ-045 SHALL cover eret with a same-cycle mtc0 to EPC: cp0_epc_i=32'h0, cp0_we_i=1, waddr=14, wdata=32'h400, giving new_pc_o=32'h400 and excepttype_o=32'he.
REQ-046 SHALL cover reset mid-sequence: rst=0 in the WAIT cycle drops busy_o=0 and flush_o=0 immediately, and an exception 1 cycle after release is handled normally.
